// File: rtl/bdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bdram_arb_pkg
// Description : Shared types and constants for the block-RAM port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bdram_arb_pkg;

    // Default RAM word-address width (128K words).
    localparam int BRAM_ADDR_W = 17;

    // Width of the fetch starvation counter (supports MAX_WAIT up to 15).
    localparam int WAIT_CNT_W  = 4;

    // Owner of the access currently in flight inside the RAM.
    typedef enum logic [1:0] {
        OWN_NONE   = 2'd0,
        OWN_IFETCH = 2'd1,
        OWN_DATA   = 2'd2
    } owner_t;

endpackage
`default_nettype wire

// File: rtl/bdram_arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module      : bdram_arb_starve_ctr
// Description : Saturating count of consecutive denied fetch cycles; raises
//               force_fetch once the fetch side has waited MAX_WAIT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module bdram_arb_starve_ctr
    import bdram_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic fetch_req,
    input  logic fetch_gnt,
    output logic force_fetch
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(MAX_WAIT);

    logic [WAIT_CNT_W-1:0] wait_cnt;

    // Count denied fetch cycles; any fetch grant or idle fetch side restarts it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wait_cnt <= '0;
        end else if (!fetch_req || fetch_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_fetch = (wait_cnt == WAIT_LIMIT);

endmodule
`default_nettype wire

// File: rtl/bdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bdram_port_arbiter
// Description : Shares one single-port 32-bit block RAM between the fetch and
//               data requesters. Data has fixed priority; a starvation counter
//               forces a fetch grant after MAX_WAIT denied cycles. Read data is
//               routed back to the owner of the access one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module bdram_port_arbiter
    import bdram_arb_pkg::*;
#(
    parameter int ADDR_W   = BRAM_ADDR_W,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              resetn,
    // Instruction fetch port
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    // Data (load/store) port
    input  logic              d_req,
    input  logic [3:0]        d_we,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    // Block RAM port A
    output logic              bram_ena,
    output logic [3:0]        bram_wea,
    output logic [ADDR_W-1:0] bram_addra,
    output logic [31:0]       bram_dina,
    input  logic [31:0]       bram_douta
);

    logic              force_fetch;
    logic              grant_i;
    logic              grant_d;
    logic [ADDR_W-1:0] i_word;
    logic [ADDR_W-1:0] d_word;
    logic [ADDR_W-1:0] addr_hold;
    logic [31:0]       din_hold;
    owner_t            owner;

    // Byte-offset and above-RAM address bits are deliberately not decoded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    assign i_word = i_addr[ADDR_W+1:2];
    assign d_word = d_addr[ADDR_W+1:2];

    bdram_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve_ctr (
        .clk         (clk),
        .resetn      (resetn),
        .fetch_req   (i_req),
        .fetch_gnt   (grant_i),
        .force_fetch (force_fetch)
    );

    // Grant select: starved fetch, then data, then fetch; nothing while in reset.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (resetn) begin
            if (force_fetch && i_req) begin
                grant_i = 1'b1;
            end else if (d_req) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end
        end
    end

    assign i_gnt = grant_i;
    assign d_gnt = grant_d;

    // RAM drive: granted side steers address/data; idle cycles replay the last value.
    always_comb begin
        bram_ena   = grant_i | grant_d;
        bram_wea   = grant_d ? d_we : 4'b0000;
        bram_addra = addr_hold;
        bram_dina  = din_hold;
        if (grant_i) begin
            bram_addra = i_word;
            bram_dina  = 32'h0;
        end else if (grant_d) begin
            bram_addra = d_word;
            bram_dina  = d_wdata;
        end
    end

    // Remember the last driven address/data so idle cycles keep the bus stable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_hold <= '0;
            din_hold  <= '0;
        end else if (grant_i || grant_d) begin
            addr_hold <= bram_addra;
            din_hold  <= bram_dina;
        end
    end

    // Record who owns the access in flight so its data returns to the right port.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            owner <= OWN_NONE;
        end else if (grant_i) begin
            owner <= OWN_IFETCH;
        end else if (grant_d) begin
            owner <= OWN_DATA;
        end else begin
            owner <= OWN_NONE;
        end
    end

    assign i_rvalid = (owner == OWN_IFETCH);
    assign d_rvalid = (owner == OWN_DATA);
    assign i_rdata  = bram_douta;
    assign d_rdata  = bram_douta;

endmodule
`default_nettype wire

// File: tb/tb_bdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bdram_port_arbiter
// Description : Self-checking bench: directed cycle table, a reset-during-
//               access sequence and randomized traffic against a reference
//               model of the arbitration rules and RAM contents.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bdram_port_arbiter;

    localparam int ADDR_W   = 17;
    localparam int MAX_WAIT = 4;
    localparam int WORDS    = 131072;
    localparam int N_RAND   = 2000;

    localparam logic [31:0] FA  = 32'h0000_0010;
    localparam logic [31:0] DA  = 32'h0000_0020;
    localparam logic [31:0] AL  = 32'h0008_0010;
    localparam logic [31:0] FW  = 32'h0984_0913;
    localparam logic [31:0] SW  = 32'hAABB_CCDD;
    localparam logic [31:0] LW  = 32'h1122_CCDD;

    logic              clk = 1'b0;
    logic              resetn;
    logic              i_req;
    logic [31:0]       i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic [3:0]        d_we;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              bram_ena;
    logic [3:0]        bram_wea;
    logic [ADDR_W-1:0] bram_addra;
    logic [31:0]       bram_dina;
    logic [31:0]       bram_douta;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem    [WORDS];
    logic [31:0] shadow [WORDS];

    always #5 clk = ~clk;

    bdram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_gnt      (i_gnt),
        .i_rvalid   (i_rvalid),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_gnt      (d_gnt),
        .d_rvalid   (d_rvalid),
        .d_rdata    (d_rdata),
        .bram_ena   (bram_ena),
        .bram_wea   (bram_wea),
        .bram_addra (bram_addra),
        .bram_dina  (bram_dina),
        .bram_douta (bram_douta)
    );

    function automatic logic [31:0] init_word(input int k);
        return (32'(k) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    // Block RAM: 1-cycle read latency, byte enables, a write returns the written word.
    initial begin
        for (int k = 0; k < WORDS; k++) mem[k] = init_word(k);
        mem[4] = FW;
        mem[8] = 32'h1122_3344;
        bram_douta = 32'h0;
        forever begin
            @(posedge clk);
            if (bram_ena) begin
                if (bram_wea != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (bram_wea[b]) mem[int'(bram_addra)][8*b +: 8] = bram_dina[8*b +: 8];
                    bram_douta <= bram_dina;
                end else begin
                    bram_douta <= mem[int'(bram_addra)];
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwe;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic        eig;
        logic        edg;
        logic [16:0] eaddra;
        logic        eiv;
        logic        edv;
        logic [31:0] erd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic eig, input logic edg, input logic [16:0] ea,
                                input logic eiv, input logic edv, input logic [31:0] erd);
        vec_t v;
        v.ireq = ir; v.iaddr = ia; v.dreq = dr; v.dwe = dw; v.daddr = da; v.dwdata = dd;
        v.eig = eig; v.edg = edg; v.eaddra = ea; v.eiv = eiv; v.edv = edv; v.erd = erd;
        return v;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'((a >> 2) & 32'h0001_FFFF);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = ($urandom & 32'hFFF8_0000) | (32'($urandom_range(64, 127)) << 2)
            | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        // Reference-model state for the random phase.
        int          wcnt;
        logic        pv_i, pv_d, ipend, dpend, eig, edg;
        logic [31:0] prd, last_din, exp_din;
        logic [16:0] last_addr, exp_addr;

        resetn = 1'b0;
        i_req = 1'b1; i_addr = FA;
        d_req = 1'b1; d_we = 4'b0000; d_addr = DA; d_wdata = 32'h0;
        for (int k = 0; k < WORDS; k++) shadow[k] = init_word(k);

        // ---- reset state: grants blocked even with both requests high ----
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset i_gnt", 32'(i_gnt), 32'h0);
        chk("reset d_gnt", 32'(d_gnt), 32'h0);
        chk("reset ena", 32'(bram_ena), 32'h0);
        chk("reset wea", 32'(bram_wea), 32'h0);
        chk("reset addra", 32'(bram_addra), 32'h0);
        chk("reset dina", bram_dina, 32'h0);
        chk("reset i_rvalid", 32'(i_rvalid), 32'h0);
        chk("reset d_rvalid", 32'(d_rvalid), 32'h0);
        i_req = 1'b0; d_req = 1'b0;
        resetn = 1'b1;

        // ---- directed cycle table ----
        vecs.push_back(mk(1, FA, 0, 0, 0, 0,      1, 0, 4, 0, 0, 0));   // lone fetch
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,      0, 0, 4, 1, 0, FW));
        vecs.push_back(mk(0, 0,  1, 4'b0011, DA, SW, 0, 1, 8, 0, 0, 0)); // store
        vecs.push_back(mk(0, 0,  1, 0, DA, 0,     0, 1, 8, 0, 1, SW));  // load
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,      0, 0, 8, 0, 1, LW));
        vecs.push_back(mk(1, FA, 1, 0, DA, 0,     0, 1, 8, 0, 0, 0));   // contention
        vecs.push_back(mk(1, FA, 0, 0, 0, 0,      1, 0, 4, 0, 1, LW));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,      0, 0, 4, 1, 0, FW));
        vecs.push_back(mk(1, AL, 0, 0, 0, 0,      1, 0, 4, 0, 0, 0));   // aliased
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,      0, 0, 4, 1, 0, FW));
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,      0, 0, 4, 0, 0, 0));   // idle
        vecs.push_back(mk(1, FA, 1, 0, DA, 0,     0, 1, 8, 0, 0, 0));   // starvation
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, FA, 1, 0, DA, 0, 0, 1, 8, 0, 1, LW));
        vecs.push_back(mk(1, FA, 1, 0, DA, 0,     1, 0, 4, 0, 1, LW));  // forced fetch
        vecs.push_back(mk(1, FA, 1, 0, DA, 0,     0, 1, 8, 1, 0, FW));  // data regranted
        for (int k = 0; k < 3; k++)
            vecs.push_back(mk(1, FA, 1, 0, DA, 0, 0, 1, 8, 0, 1, LW));
        vecs.push_back(mk(1, FA, 1, 0, DA, 0,     1, 0, 4, 0, 1, LW));  // count restarted
        vecs.push_back(mk(0, 0,  0, 0, 0, 0,      0, 0, 4, 1, 0, FW));

        foreach (vecs[n]) begin
            @(posedge clk); #1;
            i_req = vecs[n].ireq; i_addr = vecs[n].iaddr;
            d_req = vecs[n].dreq; d_we = vecs[n].dwe;
            d_addr = vecs[n].daddr; d_wdata = vecs[n].dwdata;
            @(negedge clk);
            chk($sformatf("row%0d i_gnt", n), 32'(i_gnt), 32'(vecs[n].eig));
            chk($sformatf("row%0d d_gnt", n), 32'(d_gnt), 32'(vecs[n].edg));
            chk($sformatf("row%0d ena", n), 32'(bram_ena), 32'(vecs[n].eig | vecs[n].edg));
            chk($sformatf("row%0d wea", n), 32'(bram_wea), vecs[n].edg ? 32'(vecs[n].dwe) : 32'h0);
            chk($sformatf("row%0d addra", n), 32'(bram_addra), 32'(vecs[n].eaddra));
            chk($sformatf("row%0d i_rvalid", n), 32'(i_rvalid), 32'(vecs[n].eiv));
            chk($sformatf("row%0d d_rvalid", n), 32'(d_rvalid), 32'(vecs[n].edv));
            if (vecs[n].eiv) chk($sformatf("row%0d i_rdata", n), i_rdata, vecs[n].erd);
            if (vecs[n].edv) chk($sformatf("row%0d d_rdata", n), d_rdata, vecs[n].erd);
        end

        // ---- reset while a data read is in flight ----
        @(posedge clk); #1;
        i_req = 1'b0; d_req = 1'b1; d_we = 4'b0000; d_addr = DA;
        @(negedge clk);
        chk("mid d_gnt before reset", 32'(d_gnt), 32'h1);
        #2 resetn = 1'b0;
        #1;
        chk("mid d_gnt in reset", 32'(d_gnt), 32'h0);
        chk("mid ena in reset", 32'(bram_ena), 32'h0);
        chk("mid addra in reset", 32'(bram_addra), 32'h0);
        @(posedge clk); #1;
        chk("mid d_rvalid discarded", 32'(d_rvalid), 32'h0);
        chk("mid i_rvalid discarded", 32'(i_rvalid), 32'h0);
        d_req = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        i_req = 1'b1; i_addr = FA;
        @(negedge clk);
        chk("post-reset i_gnt", 32'(i_gnt), 32'h1);
        chk("post-reset addra", 32'(bram_addra), 32'h4);
        chk("post-reset d_rvalid", 32'(d_rvalid), 32'h0);
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        chk("post-reset i_rvalid", 32'(i_rvalid), 32'h1);
        chk("post-reset i_rdata", i_rdata, FW);

        // ---- randomized traffic against the reference model ----
        wcnt = 0; pv_i = 0; pv_d = 0; prd = 0; ipend = 0; dpend = 0;
        last_addr = 17'd4; last_din = 32'h0;
        for (int n = 0; n < N_RAND; n++) begin
            @(posedge clk); #1;
            if (!ipend) begin
                i_req = ($urandom_range(0, 2) != 0);
                i_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                i_req = 1'b0;
            end
            if (!dpend) begin
                d_req = ($urandom_range(0, 3) != 0);
                d_addr = rand_addr();
                d_we = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
                d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            @(negedge clk);
            eig = i_req && ((wcnt == MAX_WAIT) || !d_req);
            edg = d_req && !eig;
            exp_addr = eig ? 17'(word_of(i_addr)) : (edg ? 17'(word_of(d_addr)) : last_addr);
            exp_din  = eig ? 32'h0 : (edg ? d_wdata : last_din);
            chk("rand i_gnt", 32'(i_gnt), 32'(eig));
            chk("rand d_gnt", 32'(d_gnt), 32'(edg));
            chk("rand ena", 32'(bram_ena), 32'(eig | edg));
            chk("rand wea", 32'(bram_wea), edg ? 32'(d_we) : 32'h0);
            chk("rand addra", 32'(bram_addra), 32'(exp_addr));
            chk("rand dina", bram_dina, exp_din);
            chk("rand i_rvalid", 32'(i_rvalid), 32'(pv_i));
            chk("rand d_rvalid", 32'(d_rvalid), 32'(pv_d));
            if (pv_i) chk("rand i_rdata", i_rdata, prd);
            if (pv_d) chk("rand d_rdata", d_rdata, prd);

            pv_i = eig;
            pv_d = edg;
            if (eig) begin
                prd = shadow[word_of(i_addr)];
            end else if (edg && d_we == 4'b0000) begin
                prd = shadow[word_of(d_addr)];
            end else if (edg) begin
                prd = d_wdata;
                for (int b = 0; b < 4; b++)
                    if (d_we[b]) shadow[word_of(d_addr)][8*b +: 8] = d_wdata[8*b +: 8];
            end
            if (i_req && !eig) wcnt = (wcnt < MAX_WAIT) ? wcnt + 1 : MAX_WAIT;
            else               wcnt = 0;
            last_addr = exp_addr;
            last_din  = exp_din;
            ipend = i_req && !eig;
            dpend = d_req && !edg;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
